// File: rtl/block_scan_ctrl_if.sv
// Purpose : bundles the scan request, memory read port and hit stream of block_scan_ctrl.
// Ports   : master = requester/memory/consumer side, slave = scan controller side.
// Timing  : mem_data is expected one cycle after mem_rd_en; hit stream is valid/ready.
interface block_scan_ctrl_if #(
  parameter int AW     = 5,
  parameter int VAL_W  = 18,
  parameter int DIST_W = 14
);
  // scan request
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [5:0]        count;
  logic [VAL_W-1:0]  thresh;
  logic [DIST_W-1:0] max_dist;
  logic              abort;
  // memory read port
  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr;
  logic [127:0]      mem_data;
  // hit stream
  logic              hit_valid;
  logic              hit_ready;
  logic [AW-1:0]     hit_addr;
  logic [1:0]        hit_slot;
  logic [VAL_W-1:0]  hit_value;
  logic [DIST_W-1:0] hit_dist;
  // status
  logic              busy;
  logic              done;
  logic [7:0]        hit_count;

  modport master (
    output start, base_addr, count, thresh, max_dist, abort, mem_data, hit_ready,
    input  mem_rd_en, mem_addr, hit_valid, hit_addr, hit_slot, hit_value, hit_dist,
           busy, done, hit_count
  );

  modport slave (
    input  start, base_addr, count, thresh, max_dist, abort, mem_data, hit_ready,
    output mem_rd_en, mem_addr, hit_valid, hit_addr, hit_slot, hit_value, hit_dist,
           busy, done, hit_count
  );
endinterface

// File: rtl/block_scan_ctrl.sv
// Purpose : scans count memory words from base_addr, emitting records with value>thresh, dist<=max_dist.
// Latency : 6 cycles per word (READ, WAIT, 4 slots) plus one cycle per hit stall; done one cycle after last slot.
// Backpressure: a hit slot holds (hit_* stable) until hit_ready; abort drops it uncounted.
// Ports   : clk, rst (async active-high), bus = block_scan_ctrl_if.slave.
module block_scan_ctrl #(
  parameter int DEPTH  = 30,
  parameter int AW     = 5,
  parameter int VAL_W  = 18,
  parameter int DIST_W = 14
) (
  input  logic           clk,
  input  logic           rst,
  block_scan_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, SCAN, DONE} state_e;

  localparam logic [5:0]    DEPTH_CNT = 6'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [5:0]        remain_q, remain_d;
  logic [VAL_W-1:0]  thresh_q, thresh_d;
  logic [DIST_W-1:0] max_dist_q, max_dist_d;
  logic [127:0]      word_q, word_d;
  logic [1:0]        slot_q, slot_d;
  logic [7:0]        hit_count_q, hit_count_d;

  logic [31:0]       rec;
  logic [VAL_W-1:0]  rec_val;
  logic [DIST_W-1:0] rec_dist;
  logic              rec_hit;
  logic [5:0]        count_clamped;
  logic [AW-1:0]     addr_next;

  // Current slot record; everything below is stable while the slot waits on hit_ready.
  assign rec      = word_q[{slot_q, 5'd0} +: 32];
  assign rec_val  = rec[31 -: VAL_W];
  assign rec_dist = rec[DIST_W-1:0];
  assign rec_hit  = (rec_val > thresh_q) && (rec_dist <= max_dist_q);

  assign count_clamped = (bus.count > DEPTH_CNT) ? DEPTH_CNT : bus.count;
  assign addr_next     = (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);

  assign bus.mem_rd_en = (state_q == READ);
  assign bus.mem_addr  = addr_q;
  assign bus.hit_valid = (state_q == SCAN) && rec_hit;
  assign bus.hit_addr  = addr_q;
  assign bus.hit_slot  = slot_q;
  assign bus.hit_value = rec_val;
  assign bus.hit_dist  = rec_dist;
  assign bus.busy      = (state_q == READ) || (state_q == WAIT) || (state_q == SCAN);
  assign bus.done      = (state_q == DONE);
  assign bus.hit_count = hit_count_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    thresh_d    = thresh_q;
    max_dist_d  = max_dist_q;
    word_d      = word_q;
    slot_d      = slot_q;
    hit_count_d = hit_count_q;

    case (state_q)
      IDLE: begin
        // start beats a simultaneous abort: abort is not looked at here
        if (bus.start) begin
          addr_d      = bus.base_addr;
          remain_d    = count_clamped;
          thresh_d    = bus.thresh;
          max_dist_d  = bus.max_dist;
          hit_count_d = '0;
          state_d     = (count_clamped == '0) ? DONE : READ;
        end
      end
      READ: begin
        state_d = bus.abort ? DONE : WAIT;
      end
      WAIT: begin
        if (bus.abort) begin
          state_d = DONE;
        end else begin
          word_d  = bus.mem_data;
          slot_d  = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (bus.abort) begin
          state_d = DONE;
        end else if (!rec_hit || bus.hit_ready) begin
          if (rec_hit) begin
            hit_count_d = hit_count_q + 8'd1;
          end
          if (slot_q == 2'd3) begin
            remain_d = remain_q - 6'd1;
            addr_d   = addr_next;
            state_d  = (remain_q == 6'd1) ? DONE : READ;
          end else begin
            slot_d = slot_q + 2'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      thresh_q    <= '0;
      max_dist_q  <= '0;
      word_q      <= '0;
      slot_q      <= '0;
      hit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      thresh_q    <= thresh_d;
      max_dist_q  <= max_dist_d;
      word_q      <= word_d;
      slot_q      <= slot_d;
      hit_count_q <= hit_count_d;
    end
  end

endmodule
